// File: rtl/phase_mon_pkg.sv
// Shared types and helpers for the phase-code sequence monitor.
package phase_mon_pkg;

  typedef logic [1:0] phase_t;

  // Upstream generator emits PH_A -> PH_B -> PH_C -> PH_D -> PH_A ...
  localparam phase_t PH_A = 2'b01;
  localparam phase_t PH_B = 2'b10;
  localparam phase_t PH_C = 2'b11;
  localparam phase_t PH_D = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACQ  = 2'b01,
    LOCK = 2'b10
  } state_t;

  // Legal successor of a phase code.
  function automatic phase_t succ(input phase_t p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; an increment beats a clear.
module sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_d, cnt_q;

  // Next count: inc with clr restarts at one, otherwise saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      if (clr_i) begin
        cnt_d = W'(1);
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + W'(1);
      end
    end else if (clr_i) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/phase_seq_monitor.sv
// Monitors a 2-bit phase-code stream: acquires lock after LOCK_LEN good
// transitions, counts completed frames (11 -> 00) and violations while locked.
module phase_seq_monitor
  import phase_mon_pkg::*;
#(
  parameter int unsigned LOCK_LEN = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned ERR_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       phase,
  input  logic             clr,
  output logic             locked,
  // 'expect' is a reserved word; this carries the code expected on the next sample.
  output logic [1:0]       expect_ph,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [3:0] LockLen = 4'(LOCK_LEN);

  state_t           state_d, state_q;
  phase_t           prev_d, prev_q;
  logic [3:0]       run_cnt_d, run_cnt_q;
  logic             locked_d, locked_q;
  phase_t           expect_d, expect_q;
  logic             frame_done_d, frame_done_q;
  logic [CNT_W-1:0] frame_cnt_d, frame_cnt_q;
  logic             err_sticky_d, err_sticky_q;

  logic good;
  logic frame;
  logic viol;

  // Classify the current sample against the previous one.
  always_comb begin
    good  = (phase == succ(prev_q));
    viol  = (state_q == LOCK) && !good;
    frame = (state_q == LOCK) && good && (phase == PH_D);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    run_cnt_d    = run_cnt_q;
    prev_d       = phase;
    expect_d     = succ(phase);
    frame_done_d = frame;
    frame_cnt_d  = frame_cnt_q;
    err_sticky_d = err_sticky_q;

    unique case (state_q)
      IDLE: begin
        state_d   = ACQ;
        run_cnt_d = '0;
      end
      ACQ: begin
        if (good) begin
          if (run_cnt_q + 4'd1 >= LockLen) begin
            state_d   = LOCK;
            run_cnt_d = '0;
          end else begin
            run_cnt_d = run_cnt_q + 4'd1;
          end
        end else begin
          run_cnt_d = '0;
        end
      end
      LOCK: begin
        if (!good) begin
          state_d   = ACQ;
          run_cnt_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        run_cnt_d = '0;
      end
    endcase

    locked_d = (state_d == LOCK);

    // Events win over a coincident clear.
    if (frame) begin
      frame_cnt_d = clr ? CNT_W'(1) : frame_cnt_q + CNT_W'(1);
    end else if (clr) begin
      frame_cnt_d = '0;
    end

    if (viol) begin
      err_sticky_d = 1'b1;
    end else if (clr) begin
      err_sticky_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      prev_q       <= PH_D;
      run_cnt_q    <= '0;
      locked_q     <= 1'b0;
      expect_q     <= PH_A;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      run_cnt_q    <= run_cnt_d;
      locked_q     <= locked_d;
      expect_q     <= expect_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .inc_i (viol),
    .clr_i (clr),
    .cnt_o (err_cnt)
  );

  assign locked     = locked_q;
  assign expect_ph  = expect_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: doc/phase_seq_monitor.md
Name: phase_seq_monitor

Overview:
Downstream consumer of the 2-bit phase-code generator FSM. That generator emits the repeating sequence 01 -> 10 -> 11 -> 00 -> 01.
This block samples the code every clock and acquires lock after a run of correct transitions. It counts completed frames, where a frame completes on each 11 -> 00 transition.
It flags and counts sequence violations, so gold and gate generator variants can be compared on observable outputs in equivalence and bring-up flows.

Parameters:
LOCK_LEN, 4, consecutive correct transitions required to enter LOCK (legal range 1..15)
CNT_W, 8, frame counter width (wraps)
ERR_W, 4, error counter width (saturates)

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-high reset
phase  in  2  phase code from upstream generator, sampled every cycle
clr  in  1  synchronous clear of frame_cnt, err_cnt, err_sticky; FSM state unaffected
locked  out  1  high while FSM in LOCK
expect  out  2  code expected on the next sample (prev+1 mod 4); 2'b01 after reset
frame_done  out  1  one-cycle pulse per completed frame while locked
frame_cnt  out  CNT_W  completed frames, wraps at 2^CNT_W
err_sticky  out  1  set on any violation in LOCK, held until clr or rst
err_cnt  out  ERR_W  violations in LOCK, saturating at all-ones

Behaviour:
- Reset (async assert, sync deassert by clk) sets:
  - state=IDLE, prev=2'b00, run_cnt=0
  - all outputs 0, except expect=2'b01
- Successor rule: succ(p) = (p + 1) mod 4. "good" = (phase == succ(prev)).
- prev <= phase every cycle outside reset. expect = succ(prev) after first sample. All outputs are registered.
- FSM, 3 states:
  - IDLE: first clock after reset captures phase into prev -> ACQ. No good/bad evaluation in this cycle.
  - ACQ:
    - good: run_cnt++. When run_cnt reaches LOCK_LEN -> LOCK and run_cnt=0. locked rises the cycle after the LOCK_LEN-th good sample.
    - bad: run_cnt=0, stay in ACQ. No error recorded, since violations before lock are acquisition noise.
  - LOCK:
    - good: stay.
    - bad: -> ACQ with run_cnt=0, locked=0 next cycle. err_sticky<=1, err_cnt saturating +1.
- Frame: in LOCK, good and phase==2'b00 (the 11 -> 00 transition):
  - frame_done=1 for exactly one cycle (next cycle); frame_cnt+1 mod 2^CNT_W.
  - The violating sample that drops lock never produces frame_done.
- clr and event in the same cycle: the event wins over the clear.
  - clr + frame -> frame_cnt=1.
  - clr + violation -> err_cnt=1, err_sticky=1.
  - clr alone -> all three cleared next cycle.
- err_cnt at all-ones stays at all-ones on further violations. err_sticky unaffected by saturation.
- Stuck input (same code repeated) counts as bad; 2 consecutive equal codes while locked = 1 violation.
- Reset mid-operation: immediate return to reset values regardless of state; counts lost.

Decomposition:
- Package phase_mon_pkg:
  - typedef phase_t (logic [1:0])
  - constants PH_A=2'b01, PH_B=2'b10, PH_C=2'b11, PH_D=2'b00
  - enum state_t {IDLE, ACQ, LOCK}
  - function succ(phase_t)
- One sub-module: sat_counter (width param, inc, clr with inc-priority, saturating), used for err_cnt.
- The frame counter is an inline wrapping register.

Test Plan:
1. Reset, then drive 01,10,11,00,01,... from the first cycle -> locked=1 the cycle after the 4th good sample; expect tracks next code; err_sticky=0.
2. Locked, continue 12 cycles -> frame_done pulses once per 11 -> 00 (3 pulses); frame_cnt=3.
3. Locked, inject 01,10,10 -> next cycle locked=0, err_sticky=1, err_cnt=1. Resume correct sequence -> relock after 4 good transitions; err_sticky stays 1.
4. Force 20 violations in lock (inject bad code after each relock) with ERR_W=4 -> err_cnt stops at 15; clr asserted in a violation cycle -> err_cnt=1.
5. CNT_W=2, run 5 frames -> frame_cnt sequence 1,2,3,0,1. clr coincident with a frame -> frame_cnt=1.
6. Assert rst asynchronously mid-LOCK (between clk edges) -> outputs return to reset values immediately; expect=01; re-acquisition needs 4 fresh good transitions.
